tick_watchdog: RTL and testbench

Programmable tick-based watchdog/timeout timer placed downstream of the prescaler counter: it consumes the counter's one-cycle `wrap` pulse as its time base (`tick`) and counts down a loaded timeout in ticks. When the timeout elapses without a `kick`, it raises a sticky interrupt that is held until acknowledged, with overrun detection for unacknowledged expiries. Used for protocol timeouts and liveness supervision of accelerator stages.

---
 rtl/tick_watchdog.sv | 155 +++++++++++++++
 tb/tb_tick_watchdog.sv | 134 +++++++++++++
 2 files changed

// File: rtl/tick_watchdog.sv
// Tick-driven watchdog: counts down a loaded timeout in prescaler ticks and raises a sticky irq on expiry.
// Optional build macro TICK_WDOG_AUTORELOAD_EN turns RUN expiry into a periodic reload.
module tick_watchdog #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             kick,
  input  logic [CNT_W-1:0] timeout_val,
  input  logic             irq_ack,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             expired,
  output logic             irq,
  output logic             overrun
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] ZERO = '0;
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_d;
  logic             expiry_evt;
  logic             irq_d, overrun_d;
  logic             tv_zero;

  assign tv_zero = (timeout_val == ZERO);

  // Next-state and counter update; control priority is stop > start > kick > tick.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    remaining_d = remaining;
    expiry_evt  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (stop) begin
          state_d     = ST_IDLE;
          remaining_d = ZERO;
        end else if (start) begin
          if (tv_zero) begin
            expiry_evt  = 1'b1;
            state_d     = ST_EXPIRED;
            remaining_d = ZERO;
          end else begin
            state_d     = ST_RUN;
            remaining_d = timeout_val;
          end
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d     = ST_IDLE;
          remaining_d = ZERO;
        end else if (start || kick) begin
          // A reload swallows any coincident tick.
          if (tv_zero) begin
            expiry_evt  = 1'b1;
            state_d     = ST_EXPIRED;
            remaining_d = ZERO;
          end else begin
            remaining_d = timeout_val;
          end
        end else if (tick) begin
          if (remaining > ONE) begin
            remaining_d = remaining - ONE;
          end else begin
            expiry_evt = 1'b1;
`ifdef TICK_WDOG_AUTORELOAD_EN
            // Periodic mode: reload and keep running unless the reload value is zero.
            if (tv_zero) begin
              state_d     = ST_EXPIRED;
              remaining_d = ZERO;
            end else begin
              state_d     = ST_RUN;
              remaining_d = timeout_val;
            end
`else
            state_d     = ST_EXPIRED;
            remaining_d = ZERO;
`endif
          end
        end
      end

      ST_EXPIRED: begin
        if (stop) begin
          state_d     = ST_IDLE;
          remaining_d = ZERO;
        end else if (start) begin
          if (tv_zero) begin
            expiry_evt  = 1'b1;
            state_d     = ST_EXPIRED;
            remaining_d = ZERO;
          end else begin
            state_d     = ST_RUN;
            remaining_d = timeout_val;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        remaining_d = ZERO;
      end
    endcase
  end

  // Sticky flags: a fresh expiry always wins over a coincident acknowledge.
  always_comb begin
    irq_d     = irq;
    overrun_d = overrun;
    if (expiry_evt) begin
      irq_d = 1'b1;
    end else if (irq_ack) begin
      irq_d = 1'b0;
    end
    if (expiry_evt && irq && !irq_ack) begin
      overrun_d = 1'b1;
    end else if (irq_ack) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      remaining <= ZERO;
      busy      <= 1'b0;
      expired   <= 1'b0;
      irq       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state_q   <= state_d;
      remaining <= remaining_d;
      busy      <= (state_d == ST_RUN);
      expired   <= (state_d == ST_EXPIRED);
      irq       <= irq_d;
      overrun   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_tick_watchdog.sv
// Directed self-checking bench for tick_watchdog; expectations are hand-computed per cycle.
// Define TICK_WDOG_AUTORELOAD_EN on both RTL and bench to exercise the periodic build.
module tb_tick_watchdog;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tick = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             kick = 1'b0;
  logic [CNT_W-1:0] timeout_val = '0;
  logic             irq_ack = 1'b0;
  logic [CNT_W-1:0] remaining;
  logic             busy, expired, irq, overrun;

  int checks = 0;
  int failures = 0;

  tick_watchdog #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .stop(stop),
    .kick(kick), .timeout_val(timeout_val), .irq_ack(irq_ack),
    .remaining(remaining), .busy(busy), .expired(expired), .irq(irq),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set before the call are sampled, then cleared.
  task automatic cyc();
    @(posedge clk);
    #1;
    tick = 1'b0; start = 1'b0; stop = 1'b0; kick = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [CNT_W-1:0] rem,
                           input logic b, input logic e, input logic i, input logic o);
    check({tag, ".remaining"}, 32'(remaining), 32'(rem));
    check({tag, ".busy"},      32'(busy),      32'(b));
    check({tag, ".expired"},   32'(expired),   32'(e));
    check({tag, ".irq"},       32'(irq),       32'(i));
    check({tag, ".overrun"},   32'(overrun),   32'(o));
  endtask

  initial begin
    #12;
    check_all("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc();

`ifdef TICK_WDOG_AUTORELOAD_EN
    // Periodic: timeout 2 with a tick every cycle.
    timeout_val = 2; start = 1; cyc();
    check_all("ar_start", 2, 1, 0, 0, 0);
    tick = 1; cyc(); check_all("ar_t1", 1, 1, 0, 0, 0);
    tick = 1; cyc(); check_all("ar_t2", 2, 1, 0, 1, 0);
    tick = 1; cyc(); check_all("ar_t3", 1, 1, 0, 1, 0);
    tick = 1; cyc(); check_all("ar_t4", 2, 1, 0, 1, 1);
    irq_ack = 1; cyc(); check_all("ar_ack", 2, 1, 0, 0, 0);
    timeout_val = 0; kick = 1; cyc();
    check_all("ar_zero_kick", 0, 0, 1, 1, 0);
`else
    // One-shot: timeout 3, tick every 4 cycles; timeout_val changes mid-run are ignored.
    timeout_val = 3; start = 1; cyc();
    check_all("start3", 3, 1, 0, 0, 0);
    timeout_val = 9;
    cyc(); cyc(); cyc();
    check("hold.remaining", 32'(remaining), 32'd3);
    tick = 1; cyc(); check_all("tick1", 2, 1, 0, 0, 0);
    cyc(); cyc(); cyc();
    tick = 1; cyc(); check_all("tick2", 1, 1, 0, 0, 0);
    cyc(); cyc(); cyc();
    tick = 1; cyc(); check_all("tick3_expire", 0, 0, 1, 1, 0);
    tick = 1; kick = 1; cyc(); check_all("exp_ignore", 0, 0, 1, 1, 0);
    irq_ack = 1; cyc(); check_all("ack", 0, 0, 1, 0, 0);

    // Kick with coincident tick at remaining==1 reloads, tick dropped.
    timeout_val = 2; start = 1; cyc();
    tick = 1; cyc(); check("kick_pre.remaining", 32'(remaining), 32'd1);
    timeout_val = 5; kick = 1; tick = 1; cyc();
    check_all("kick_tick", 5, 1, 0, 0, 0);

    // Restart to 4, then stop.
    timeout_val = 4; start = 1; cyc(); check_all("restart4", 4, 1, 0, 0, 0);
    stop = 1; start = 1; cyc(); check_all("stop", 0, 0, 0, 0, 0);
    tick = 1; kick = 1; cyc(); check_all("idle_ignore", 0, 0, 0, 0, 0);

    // Zero timeout from IDLE expires immediately.
    timeout_val = 0; start = 1; cyc(); check_all("start0", 0, 0, 1, 1, 0);

    // Expiry with irq pending and no ack -> overrun.
    timeout_val = 1; start = 1; cyc(); check_all("restart1", 1, 1, 0, 1, 0);
    tick = 1; cyc(); check_all("overrun", 0, 0, 1, 1, 1);
    irq_ack = 1; cyc(); check_all("ack2", 0, 0, 1, 0, 0);

    // Same, but acked on the expiry cycle: irq stays, no overrun.
    timeout_val = 0; start = 1; cyc(); check_all("start0b", 0, 0, 1, 1, 0);
    timeout_val = 1; start = 1; cyc();
    tick = 1; irq_ack = 1; cyc(); check_all("ack_on_expiry", 0, 0, 1, 1, 0);

    // Stop from EXPIRED keeps sticky flags.
    stop = 1; cyc(); check_all("stop_exp", 0, 0, 0, 1, 0);
    irq_ack = 1; cyc(); check("ack3.irq", 32'(irq), 32'd0);
`endif

    // Async reset mid-run clears outputs without a clock edge.
    timeout_val = 7; start = 1; cyc();
    tick = 1; cyc(); check("pre_rst.remaining", 32'(remaining), 32'd6);
    #2 rst_n = 1'b0;
    #1 check_all("async_rst", 0, 0, 0, 0, 0);
    cyc(); check_all("rst_held", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(); check_all("post_rst", 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
